// File: rtl/writeback_stage.sv
// Writeback stage: arbitrates ALU and load results onto the register-file write port
// and tracks outstanding destinations. Define WRITEBACK_LOAD_EXT_EN for load byte/half extraction.
module writeback_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    input  logic [2:0]  mem_funct3,
    input  logic [1:0]  mem_addr_low,
    output logic        mem_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        rf_we,
    output logic [4:0]  rf_select_d,
    output logic [31:0] rf_input_d,
    output logic [31:0] busy_mask,
    output logic        load_err
);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } wb_res_t;

    logic    rr_ptr;
    logic    conflict;
    logic    accept;
    wb_res_t mem_res;
    wb_res_t sel_res;
    logic [31:0] busy_set;
    logic [31:0] busy_clr;

    // rr_ptr=0 favours mem, 1 favours ALU; only consulted when both offer.
    assign conflict  = !reset && alu_valid && mem_valid;
    assign alu_ready = !reset && alu_valid && (!mem_valid || rr_ptr);
    assign mem_ready = !reset && mem_valid && (!alu_valid || !rr_ptr);
    assign accept    = alu_ready || mem_ready;

`ifdef WRITEBACK_LOAD_EXT_EN
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v      = mem_data[{mem_addr_low, 3'b000} +: 8];
        half_v      = mem_addr_low[1] ? mem_data[31:16] : mem_data[15:0];
        mem_res.rd  = mem_rd;
        mem_res.err = 1'b0;
        case (mem_funct3)
            3'd0:    mem_res.data = {{24{byte_v[7]}}, byte_v};
            3'd1:    mem_res.data = {{16{half_v[15]}}, half_v};
            3'd2:    mem_res.data = mem_data;
            3'd4:    mem_res.data = {24'd0, byte_v};
            3'd5:    mem_res.data = {16'd0, half_v};
            default: begin
                mem_res.data = mem_data;
                mem_res.err  = 1'b1;
            end
        endcase
    end
`else
    logic unused_load_fields;

    assign unused_load_fields = ^{mem_funct3, mem_addr_low};
    assign mem_res = '{rd: mem_rd, data: mem_data, err: 1'b0};
`endif

    assign sel_res  = mem_ready ? mem_res : '{rd: alu_rd, data: alu_data, err: 1'b0};
    assign busy_set = issue_valid ? (32'd1 << issue_rd) : 32'd0;
    assign busy_clr = accept ? (32'd1 << sel_res.rd) : 32'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr      <= 1'b0;
            rf_we       <= 1'b0;
            rf_select_d <= 5'd0;
            rf_input_d  <= 32'd0;
            busy_mask   <= 32'd0;
            load_err    <= 1'b0;
        end else begin
            if (conflict)
                rr_ptr <= !rr_ptr;
            rf_we    <= accept && (sel_res.rd != 5'd0);
            load_err <= mem_ready && mem_res.err;
            if (accept) begin
                rf_select_d <= sel_res.rd;
                rf_input_d  <= sel_res.data;
            end
            // Set is applied after clear so a same-cycle reissue keeps the bit.
            busy_mask <= ((busy_mask & ~busy_clr) | busy_set) & ~32'd1;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: vector table for single-channel traffic,
// hand sequences for arbitration and reset corner cases.
module tb_writeback_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_low;
    logic        mem_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        rf_we;
    logic [4:0]  rf_select_d;
    logic [31:0] rf_input_d;
    logic [31:0] busy_mask;
    logic        load_err;

`ifdef WRITEBACK_LOAD_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    writeback_stage dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .mem_funct3(mem_funct3), .mem_addr_low(mem_addr_low), .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rf_we(rf_we), .rf_select_d(rf_select_d), .rf_input_d(rf_input_d),
        .busy_mask(busy_mask), .load_err(load_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic [2:0]  f3;
        logic [1:0]  al;
        logic        iv;
        logic [4:0]  ird;
        logic        e_ar;
        logic        e_mr;
        logic        e_we;
        logic [4:0]  e_sel;
        logic [31:0] e_data;
        logic        e_err;
        logic [31:0] e_busy;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tv[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t alu_v(input logic [4:0] rd, input logic [31:0] d,
                                   input logic iv, input logic [4:0] ird, input logic [31:0] busy);
        vec_t v;
        v = '{av: 1'b1, ard: rd, adata: d, mv: 1'b0, mrd: 5'd0, mdata: 32'd0, f3: 3'd0, al: 2'd0,
              iv: iv, ird: ird, e_ar: 1'b1, e_mr: 1'b0, e_we: (rd != 5'd0), e_sel: rd, e_data: d,
              e_err: 1'b0, e_busy: busy};
        return v;
    endfunction

    function automatic vec_t mem_v(input logic [4:0] rd, input logic [31:0] d, input logic [2:0] f3,
                                   input logic [1:0] al, input logic [31:0] ext_d, input logic err,
                                   input logic [31:0] busy);
        vec_t v;
        v = '{av: 1'b0, ard: 5'd0, adata: 32'd0, mv: 1'b1, mrd: rd, mdata: d, f3: f3, al: al,
              iv: 1'b0, ird: 5'd0, e_ar: 1'b0, e_mr: 1'b1, e_we: 1'b1, e_sel: rd,
              e_data: EXT ? ext_d : d, e_err: EXT && err, e_busy: busy};
        return v;
    endfunction

    function automatic vec_t idle_v(input logic iv, input logic [4:0] ird, input logic [31:0] busy);
        vec_t v;
        v = '{av: 1'b0, ard: 5'd0, adata: 32'd0, mv: 1'b0, mrd: 5'd0, mdata: 32'd0, f3: 3'd0, al: 2'd0,
              iv: iv, ird: ird, e_ar: 1'b0, e_mr: 1'b0, e_we: 1'b0, e_sel: 5'd0, e_data: 32'd0,
              e_err: 1'b0, e_busy: busy};
        return v;
    endfunction

    task automatic drive_idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0; mem_funct3 = 0; mem_addr_low = 0;
        issue_valid = 0; issue_rd = 0;
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();

        tv[0]  = idle_v(1'b1, 5'd5, 32'h0000_0020);
        tv[1]  = alu_v(5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'h0);
        tv[2]  = idle_v(1'b1, 5'd10, 32'h0000_0400);
        tv[3]  = mem_v(5'd10, 32'h80FF_0000, 3'd0, 2'd3, 32'hFFFF_FF80, 1'b0, 32'h0);
        tv[4]  = mem_v(5'd11, 32'h80FF_0000, 3'd4, 2'd3, 32'h0000_0080, 1'b0, 32'h0);
        tv[5]  = mem_v(5'd12, 32'h80FF_0000, 3'd5, 2'd2, 32'h0000_80FF, 1'b0, 32'h0);
        tv[6]  = mem_v(5'd13, 32'h1234_8001, 3'd1, 2'd1, 32'hFFFF_8001, 1'b0, 32'h0);
        tv[7]  = mem_v(5'd14, 32'hCAFE_BABE, 3'd2, 2'd0, 32'hCAFE_BABE, 1'b0, 32'h0);
        tv[8]  = mem_v(5'd15, 32'h0000_55AA, 3'd3, 2'd1, 32'h0000_55AA, 1'b1, 32'h0);
        tv[9]  = alu_v(5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
        tv[10] = idle_v(1'b1, 5'd7, 32'h0000_0080);
        tv[11] = alu_v(5'd7, 32'h0000_0001, 1'b1, 5'd7, 32'h0000_0080);
        tv[12] = alu_v(5'd7, 32'h0000_0002, 1'b0, 5'd0, 32'h0);
        tv[13] = mem_v(5'd3, 32'h0000_7F00, 3'd0, 2'd1, 32'h0000_007F, 1'b0, 32'h0);
        tv[14] = mem_v(5'd16, 32'h0BAD_F00D, 3'd6, 2'd0, 32'h0BAD_F00D, 1'b1, 32'h0);
        tv[15] = mem_v(5'd17, 32'h8765_4321, 3'd1, 2'd3, 32'h0000_8765, 1'b0, 32'h0);
        tv[16] = idle_v(1'b0, 5'd0, 32'h0);
        // LH at offset 3 takes the upper half: 0x8765 sign-extends.
        tv[15].e_data = EXT ? 32'hFFFF_8765 : 32'h8765_4321;

        // Reset state
        @(posedge clock); @(posedge clock); #1;
        chk("rst_ready", {31'd0, alu_ready | mem_ready}, 32'd0);
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_sel", {27'd0, rf_select_d}, 32'd0);
        chk("rst_data", rf_input_d, 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
        chk("rst_err", {31'd0, load_err}, 32'd0);
        @(negedge clock); reset = 1'b0;

        // Single-channel vector table
        for (int i = 0; i < 17; i++) begin
            @(negedge clock);
            alu_valid = tv[i].av; alu_rd = tv[i].ard; alu_data = tv[i].adata;
            mem_valid = tv[i].mv; mem_rd = tv[i].mrd; mem_data = tv[i].mdata;
            mem_funct3 = tv[i].f3; mem_addr_low = tv[i].al;
            issue_valid = tv[i].iv; issue_rd = tv[i].ird;
            #1;
            if (tv[i].av) chk($sformatf("v%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, tv[i].e_ar});
            if (tv[i].mv) chk($sformatf("v%0d_mem_ready", i), {31'd0, mem_ready}, {31'd0, tv[i].e_mr});
            @(posedge clock); #1;
            chk($sformatf("v%0d_we", i), {31'd0, rf_we}, {31'd0, tv[i].e_we});
            chk($sformatf("v%0d_err", i), {31'd0, load_err}, {31'd0, tv[i].e_err});
            chk($sformatf("v%0d_busy", i), busy_mask, tv[i].e_busy);
            if (tv[i].e_we) begin
                chk($sformatf("v%0d_sel", i), {27'd0, rf_select_d}, {27'd0, tv[i].e_sel});
                chk($sformatf("v%0d_data", i), rf_input_d, tv[i].e_data);
            end
        end

        // Arbitration right after reset: mem, ALU, mem
        @(negedge clock); drive_idle(); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h0000_00A1;
        mem_valid = 1; mem_rd = 5'd2; mem_data = 32'h0000_00B2; mem_funct3 = 3'd2;
        for (int c = 0; c < 3; c++) begin
            logic exp_mem;
            exp_mem = (c != 1);
            #1;
            chk($sformatf("rr%0d_mem_ready", c), {31'd0, mem_ready}, {31'd0, exp_mem});
            chk($sformatf("rr%0d_alu_ready", c), {31'd0, alu_ready}, {31'd0, !exp_mem});
            @(posedge clock); #1;
            chk($sformatf("rr%0d_we", c), {31'd0, rf_we}, 32'd1);
            chk($sformatf("rr%0d_sel", c), {27'd0, rf_select_d}, exp_mem ? 32'd2 : 32'd1);
            chk($sformatf("rr%0d_data", c), rf_input_d, exp_mem ? 32'hB2 : 32'hA1);
            @(negedge clock);
        end

        // Reset wins over a pending bad load and an issue
        drive_idle();
        issue_valid = 1; issue_rd = 5'd9;
        @(negedge clock);
        reset = 1'b1; issue_rd = 5'd6;
        mem_valid = 1; mem_rd = 5'd4; mem_data = 32'h1111_2222; mem_funct3 = 3'd3;
        #1;
        chk("rstq_mem_ready", {31'd0, mem_ready}, 32'd0);
        @(posedge clock); #1;
        chk("rstq_we", {31'd0, rf_we}, 32'd0);
        chk("rstq_err", {31'd0, load_err}, 32'd0);
        chk("rstq_busy", busy_mask, 32'd0);
        chk("rstq_data", rf_input_d, 32'd0);
        @(negedge clock); drive_idle(); reset = 1'b0;
        @(posedge clock); #1;
        chk("post_rst_we", {31'd0, rf_we}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
